// File: rtl/timer_prescaler.sv
// Clock-enable prescaler for the 8-bit timer: power-of-two or arbitrary divide-by-N,
// with ratio changes staged until a period boundary. Optional clk_out via TIMER_PRESCALER_CLKOUT_EN.
module timer_prescaler #(
    parameter int CNT_W = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             mode,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic             tick,
`ifdef TIMER_PRESCALER_CLKOUT_EN
    output logic             clk_out,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             pend
);

    logic             act_mode;
    logic [SEL_W-1:0] act_sel;
    logic [CNT_W-1:0] act_val;
    logic             pnd_mode;
    logic [SEL_W-1:0] pnd_sel;
    logic [CNT_W-1:0] pnd_val;

    logic [CNT_W:0]   n_full;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt_next;
    logic             at_term;
    logic             apply;
    int               shamt;

    // N is formed one bit wider so that 2^CNT_W is representable; term is N-1 truncated.
    always_comb begin
        n_full = '0;
        shamt  = 0;
        if (act_mode) begin
            n_full = (CNT_W+1)'(act_val) + (CNT_W+1)'(1);
        end else begin
            shamt = int'(act_sel) + 1;
            if (shamt > CNT_W)
                shamt = CNT_W;
            n_full = (CNT_W+1)'(1) << shamt;
        end
        term = CNT_W'(n_full - (CNT_W+1)'(1));
    end

    assign at_term = (cnt == term);
    // Frozen counter is a safe boundary too: no partial period is in flight to the timer.
    assign apply   = pend & (~en | at_term);

    always_comb begin
        cnt_next = cnt;
        if (apply)
            cnt_next = '0;
        else if (en)
            cnt_next = at_term ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= en & at_term;
        end
    end

`ifdef TIMER_PRESCALER_CLKOUT_EN
    logic [CNT_W-1:0] half;

    assign half = CNT_W'(n_full >> 1);

    // Low for floor(N/2) counts, high for the remaining ceil(N/2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clk_out <= 1'b0;
        else if (apply)
            clk_out <= 1'b0;
        else if (en)
            clk_out <= (cnt_next >= half);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_mode <= 1'b0;
            act_sel  <= '0;
            act_val  <= '0;
            pnd_mode <= 1'b0;
            pnd_sel  <= '0;
            pnd_val  <= '0;
            pend     <= 1'b0;
        end else begin
            if (apply) begin
                act_mode <= pnd_mode;
                act_sel  <= pnd_sel;
                act_val  <= pnd_val;
            end
            // A load on the apply edge queues behind the value being applied.
            if (load) begin
                pnd_mode <= mode;
                pnd_sel  <= div_sel;
                pnd_val  <= div_val;
                pend     <= 1'b1;
            end else if (apply) begin
                pend     <= 1'b0;
            end
        end
    end

endmodule
